rast_sample_scheduler: RTL and testbench
========================================

// Module: rast_sample_scheduler
// PURPOSE
//  Sequences the rasterizer sample stage. Accepts one triangle plus its snapped bounding box
//  from the bbox pipe and walks the sample grid row-major, one sample per cycle, at the MSAA
//  rate. Drives each (triangle, sample) pair into the hash/sample pipes and back-pressures
//  the bbox pipe via halt_RnnnnL while a box is in progress.
// PARAMETERS
//  SIGFIG  24  bits per position/colour word (signed fixed point)
//  RADIX   10  fraction bits in SIGFIG words
//  VERTS    3  vertices per micropolygon
//  AXIS     3  axes per vertex (x,y,z)
//  COLORS   3  colour channels
// PORTS
//  clk             in   1                     clock
//  rst             in   1                     synchronous reset, active high
//  tri_R10S        in   VERTS*AXIS*SIGFIG     triangle vertices from bbox pipe
//  color_R10U      in   COLORS*SIGFIG         triangle colour
//  box_R10S        in   2*2*SIGFIG            box [0]=LL,[1]=UR; [x]=0,[y]=1; grid-snapped
//  validTri_R10H   in   1                     triangle/box valid
//  subSample_RnnnnU in  4                     one-hot MSAA mode (1000=1x,0100=4x,0010=16x,0001=64x)
//  halt_RnnnnL     out  1                     1 = may accept a triangle; 0 = bbox pipe must hold
//  ready_R13H      in   1                     downstream accepts the current sample
//  tri_R13S        out  VERTS*AXIS*SIGFIG     latched triangle
//  color_R13U      out  COLORS*SIGFIG         latched colour
//  sample_R13S     out  2*SIGFIG              sample position [0]=x,[1]=y
//  validSamp_R13H  out  1                     sample valid
// BEHAVIOUR
//  - Reset: state=WAIT; halt_RnnnnL=1; validSamp_R13H=0; tri/color/sample outputs=0.
//  - Step: 1000->2^RADIX (1.0), 0100->2^(RADIX-1), 0010->2^(RADIX-2), 0001->2^(RADIX-3);
//    illegal or zero code -> 1.0. Mode is sampled at acceptance and held for the whole box.
//  - Accept: WAIT & validTri_R10H (halt_RnnnnL=1) in cycle N -> latch tri, colour, box, step;
//    sample:=LL; validSamp=1 in N+1; state=TEST; halt_RnnnnL=0 from N+1.
//  - Advance: in TEST, fire = validSamp & ready_R13H. On fire:
//      x+step <= URx        -> x += step
//      else, y+step <= URy  -> x := LLx, y += step
//      else (last sample)   -> validSamp=0, state=WAIT, halt_RnnnnL=1 next cycle
//  - No fire: sample, tri, colour and validSamp hold stable; ready may drop at any time.
//  - Compares are signed, SIGFIG+1 bits wide so x+step never wraps near the max coordinate.
//  - Single-point box (LL==UR): exactly one sample, then WAIT.
//  - validTri_R10H while in TEST is ignored; upstream holds it under halt_RnnnnL=0.
//  - Throughput: 1 sample/cycle with ready held; one idle cycle between back-to-back boxes.
//  - rst mid-box: abandon box, return to reset values next cycle; no partial flush.
//  - FSM: WAIT(accept) -> TEST(emit) -> WAIT. Only two states; no illegal-state recovery
//    beyond reset.
// STRUCTURE
//  - rast_params gains: typedef sample_t (2xSIGFIG signed), box_t (2x2xSIGFIG),
//    tri_t (VERTSxAXISxSIGFIG), color_t, enum sched_state_t {WAIT,TEST}.
//    The one-hot code constants live there too.
//  - Sub-module rast_step_gen: combinational subSample -> step map, reused by the bbox snapper.
//  - Everything else is one always_ff block plus next-state logic. No pipe registers beyond
//    R13; PIPES_ITER=1.
// TESTING
//  1x, box LL=(0,0) UR=(2.0,1.0), ready=1 -> 6 samples (0,0)(1,0)(2,0)(0,1)(1,1)(2,1),
//    cycles N+1..N+6; halt_RnnnnL=1 at N+7.
//  4x, LL=UR=(5.0,5.0) -> exactly one sample (5.0,5.0); back in WAIT after one fire.
//  16x, LL=(0,0) UR=(0.5,0.25), ready toggled 1010... -> 6 samples at 0.25 step, each held
//    stable while ready=0.
//  Box near max positive coordinate, step 1.0 -> no wrap to negative; row advance correct.
//  Back-to-back triangles, validTri held high -> second box's first sample 1 idle cycle after
//    the first box's last; subSample changed mid-box ignored.
//  rst asserted mid-box at sample 3 -> validSamp=0, halt_RnnnnL=1 next cycle; new tri
//    accepted and walked from its LL.

Source files
------------

// File: rtl/rast_sample_scheduler_pkg.sv
// rtl/rast_sample_scheduler_pkg.sv - shared widths, types and MSAA codes for the sample scheduler
package rast_sample_scheduler_pkg;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  localparam int TRI_W   = VERTS * AXIS * SIGFIG;
  localparam int COLOR_W = COLORS * SIGFIG;

  // One-hot MSAA mode codes
  localparam logic [3:0] SS_1X  = 4'b1000;
  localparam logic [3:0] SS_4X  = 4'b0100;
  localparam logic [3:0] SS_16X = 4'b0010;
  localparam logic [3:0] SS_64X = 4'b0001;

  // 1.0 in RADIX fixed point
  localparam logic [SIGFIG-1:0] STEP_ONE = SIGFIG'(1) << RADIX;

  typedef logic [SIGFIG-1:0]            word_t;
  typedef logic [1:0][SIGFIG-1:0]       sample_t;  // [0]=x, [1]=y
  typedef logic [1:0][1:0][SIGFIG-1:0]  box_t;     // [0]=LL, [1]=UR
  typedef logic [TRI_W-1:0]             tri_t;
  typedef logic [COLOR_W-1:0]           color_t;

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } sched_state_t;

endpackage

// File: rtl/rast_step_gen.sv
// rtl/rast_step_gen.sv - maps the one-hot MSAA code to a fixed-point grid step
module rast_step_gen
  import rast_sample_scheduler_pkg::*;
(
  input  logic [3:0]        sub_sample,
  output logic [SIGFIG-1:0] step
);

  // Unknown or empty codes fall back to one sample per pixel
  always_comb begin
    step = STEP_ONE;
    case (sub_sample)
      SS_1X:   step = STEP_ONE;
      SS_4X:   step = STEP_ONE >> 1;
      SS_16X:  step = STEP_ONE >> 2;
      SS_64X:  step = STEP_ONE >> 3;
      default: step = STEP_ONE;
    endcase
  end

endmodule

// File: rtl/rast_sample_scheduler.sv
// rtl/rast_sample_scheduler.sv - walks a triangle's bounding box row-major, one sample per cycle
module rast_sample_scheduler
  import rast_sample_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TRI_W-1:0]      tri_R10S,
  input  logic [COLOR_W-1:0]    color_R10U,
  input  logic [4*SIGFIG-1:0]   box_R10S,
  input  logic                  validTri_R10H,
  input  logic [3:0]            subSample_RnnnnU,
  output logic                  halt_RnnnnL,
  input  logic                  ready_R13H,
  output logic [TRI_W-1:0]      tri_R13S,
  output logic [COLOR_W-1:0]    color_R13U,
  output logic [2*SIGFIG-1:0]   sample_R13S,
  output logic                  validSamp_R13H
);

  sched_state_t state_q, state_d;
  tri_t         tri_q, tri_d;
  color_t       color_q, color_d;
  sample_t      sample_q, sample_d;
  sample_t      ur_q, ur_d;
  word_t        ll_x_q, ll_x_d;
  word_t        step_q, step_d;
  word_t        step_w;
  box_t         box_in;

  logic                accept;
  logic                fire;
  logic                x_ok;
  logic                y_ok;
  logic signed [SIGFIG:0] nx;
  logic signed [SIGFIG:0] ny;

  assign box_in = box_R10S;

  rast_step_gen u_step_gen (
    .sub_sample (subSample_RnnnnU),
    .step       (step_w)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT;
    else     state_q <= state_d;
  end

  // FSM next state: leave TEST only when the last sample of the box is taken
  always_comb begin
    state_d = state_q;
    if (state_q == WAIT) begin
      if (validTri_R10H) state_d = TEST;
    end else begin
      if (fire && !x_ok && !y_ok) state_d = WAIT;
    end
  end

  // FSM outputs: a sample is valid exactly while a box is being walked
  always_comb begin
    halt_RnnnnL    = (state_q == WAIT);
    validSamp_R13H = (state_q == TEST);
  end

  // Grid stepping; one extra bit so a step past the max coordinate cannot wrap negative
  always_comb begin
    accept   = (state_q == WAIT) && validTri_R10H;
    fire     = (state_q == TEST) && ready_R13H;
    nx       = $signed({sample_q[0][SIGFIG-1], sample_q[0]}) + $signed({1'b0, step_q});
    ny       = $signed({sample_q[1][SIGFIG-1], sample_q[1]}) + $signed({1'b0, step_q});
    x_ok     = nx <= $signed({ur_q[0][SIGFIG-1], ur_q[0]});
    y_ok     = ny <= $signed({ur_q[1][SIGFIG-1], ur_q[1]});
    tri_d    = tri_q;
    color_d  = color_q;
    sample_d = sample_q;
    ur_d     = ur_q;
    ll_x_d   = ll_x_q;
    step_d   = step_q;
    if (accept) begin
      tri_d    = tri_R10S;
      color_d  = color_R10U;
      sample_d = box_in[0];
      ur_d     = box_in[1];
      ll_x_d   = box_in[0][0];
      step_d   = step_w;
    end else if (fire) begin
      if (x_ok) begin
        sample_d[0] = nx[SIGFIG-1:0];
      end else if (y_ok) begin
        sample_d[0] = ll_x_q;
        sample_d[1] = ny[SIGFIG-1:0];
      end
    end
  end

  // Datapath registers; reset clears everything so a mid-box reset leaves no residue
  always_ff @(posedge clk) begin
    if (rst) begin
      tri_q    <= '0;
      color_q  <= '0;
      sample_q <= '0;
      ur_q     <= '0;
      ll_x_q   <= '0;
      step_q   <= '0;
    end else begin
      tri_q    <= tri_d;
      color_q  <= color_d;
      sample_q <= sample_d;
      ur_q     <= ur_d;
      ll_x_q   <= ll_x_d;
      step_q   <= step_d;
    end
  end

  assign tri_R13S    = tri_q;
  assign color_R13U  = color_q;
  assign sample_R13S = sample_q;

endmodule

// File: tb/tb_rast_sample_scheduler.sv
// tb/tb_rast_sample_scheduler.sv - randomized self-checking bench for rast_sample_scheduler
module tb_rast_sample_scheduler;
  import rast_sample_scheduler_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [TRI_W-1:0]     tri_R10S = '0;
  logic [COLOR_W-1:0]   color_R10U = '0;
  logic [4*SIGFIG-1:0]  box_R10S = '0;
  logic                 validTri_R10H = 1'b0;
  logic [3:0]           subSample_RnnnnU = 4'b1000;
  logic                 halt_RnnnnL;
  logic                 ready_R13H = 1'b0;
  logic [TRI_W-1:0]     tri_R13S;
  logic [COLOR_W-1:0]   color_R13U;
  logic [2*SIGFIG-1:0]  sample_R13S;
  logic                 validSamp_R13H;

  int n_checks = 0;
  int n_fail   = 0;

  rast_sample_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R10S         (tri_R10S),
    .color_R10U       (color_R10U),
    .box_R10S         (box_R10S),
    .validTri_R10H    (validTri_R10H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnL      (halt_RnnnnL),
    .ready_R13H       (ready_R13H),
    .tri_R13S         (tri_R13S),
    .color_R13U       (color_R13U),
    .sample_R13S      (sample_R13S),
    .validSamp_R13H   (validSamp_R13H)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [TRI_W-1:0] got, input logic [TRI_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Samples per pixel edge for each MSAA mode; anything else is one sample per pixel
  function automatic int model_step(input logic [3:0] m);
    int per_edge;
    case (m)
      4'b1000: per_edge = 1;
      4'b0100: per_edge = 2;
      4'b0010: per_edge = 4;
      4'b0001: per_edge = 8;
      default: per_edge = 1;
    endcase
    return 1024 / per_edge;
  endfunction

  // Called just after a negedge with the DUT idle. rmode: 0=ready held, 1=1010.., 2=random.
  // hold keeps validTri high (and scrambles the mode) during the box; abort_at>=0 raises rst
  // while the sample with that index is on the outputs.
  task automatic run_box(input int llx, input int lly, input int urx, input int ury,
                         input logic [3:0] mode, input int rmode, input bit hold,
                         input int abort_at);
    logic [TRI_W-1:0]   t;
    logic [COLOR_W-1:0] c;
    int  step;
    int  qx[$];
    int  qy[$];
    int  popped;
    int  cyc;
    bit  rdy;
    step   = model_step(mode);
    popped = 0;
    cyc    = 0;
    for (int y = lly; y <= ury; y += step)
      for (int x = llx; x <= urx; x += step) begin
        qx.push_back(x);
        qy.push_back(y);
      end
    for (int i = 0; i < TRI_W; i++)   t[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < COLOR_W; i++) c[i] = 1'($urandom_range(0, 1));
    check("idle_halt", {215'd0, halt_RnnnnL}, 216'd1);
    tri_R10S         = t;
    color_R10U       = c;
    box_R10S         = {SIGFIG'(ury), SIGFIG'(urx), SIGFIG'(lly), SIGFIG'(llx)};
    subSample_RnnnnU = mode;
    validTri_R10H    = 1'b1;
    @(posedge clk);
    while (qx.size() > 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (hold) subSample_RnnnnU = 4'($urandom_range(0, 15));
      else      validTri_R10H = 1'b0;
      check("valid", {215'd0, validSamp_R13H}, 216'd1);
      check("busy_halt", {215'd0, halt_RnnnnL}, 216'd0);
      check("sample", {168'd0, sample_R13S}, {168'd0, SIGFIG'(qy[0]), SIGFIG'(qx[0])});
      check("tri", tri_R13S, t);
      check("color", {144'd0, color_R13U}, {144'd0, c});
      if (popped == abort_at) begin
        rst = 1'b1;
        return;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready_R13H = rdy;
      if (rdy) begin
        void'(qx.pop_front());
        void'(qy.pop_front());
        popped++;
      end
    end
    check("budget_left", 216'(qx.size()), 216'd0);
    @(negedge clk);
    check("end_valid", {215'd0, validSamp_R13H}, 216'd0);
    check("end_halt", {215'd0, halt_RnnnnL}, 216'd1);
  endtask

  initial begin
    int m_sel;
    int st;
    int lx;
    int ly;
    logic [3:0] codes [6];
    codes[0] = 4'b1000; codes[1] = 4'b0100; codes[2] = 4'b0010;
    codes[3] = 4'b0001; codes[4] = 4'b0000; codes[5] = 4'b1100;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_halt", {215'd0, halt_RnnnnL}, 216'd1);
    check("rst_valid", {215'd0, validSamp_R13H}, 216'd0);
    check("rst_sample", {168'd0, sample_R13S}, 216'd0);
    check("rst_tri", tri_R13S, 216'd0);
    check("rst_color", {144'd0, color_R13U}, 216'd0);
    rst = 1'b0;
    @(negedge clk);

    run_box(0, 0, 2048, 1024, 4'b1000, 0, 1'b0, -1);
    run_box(5120, 5120, 5120, 5120, 4'b0100, 0, 1'b0, -1);
    run_box(0, 0, 512, 256, 4'b0010, 1, 1'b0, -1);
    run_box(8189 * 1024, 8190 * 1024, 8191 * 1024, 8191 * 1024, 4'b1000, 0, 1'b0, -1);

    run_box(-1024, 0, 1024, 512, 4'b0001, 0, 1'b1, -1);
    run_box(0, -2048, 1024, -1024, 4'b1000, 2, 1'b0, -1);

    run_box(0, 0, 3072, 0, 4'b1000, 0, 1'b0, 2);
    @(negedge clk);
    check("abort_valid", {215'd0, validSamp_R13H}, 216'd0);
    check("abort_halt", {215'd0, halt_RnnnnL}, 216'd1);
    check("abort_sample", {168'd0, sample_R13S}, 216'd0);
    check("abort_tri", tri_R13S, 216'd0);
    rst = 1'b0;
    @(negedge clk);
    run_box(1024, 1024, 2048, 2048, 4'b1000, 2, 1'b0, -1);

    for (int k = 0; k < 8; k++) begin
      m_sel = $urandom_range(0, 5);
      st    = model_step(codes[m_sel]);
      lx    = (int'($urandom_range(0, 200)) - 100) * st;
      ly    = (int'($urandom_range(0, 200)) - 100) * st;
      run_box(lx, ly, lx + int'($urandom_range(0, 3)) * st + int'($urandom_range(0, st - 1)),
              ly + int'($urandom_range(0, 3)) * st, codes[m_sel], 2, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
